gemm_operand_loader: RTL and testbench

Upstream feeder for the GEMM compute stage. It accepts a single valid/ready word stream, unpacks one frame into the alpha/beta scalars and the A, B and C operand banks, and pulses start to the GEMM block. It then holds the operands stable until the GEMM block reports done. The frame is length-checked, and malformed frames never trigger a computation.

---
 rtl/gemm_pkg.sv | 39 +++
 rtl/gemm_frame_decoder.sv | 50 +++++
 rtl/gemm_operand_loader.sv | 148 ++++++++++++++
 tb/tb_gemm_operand_loader.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/gemm_pkg.sv
// Shared types, frame layout offsets and sizing helpers for the GEMM operand path.
package gemm_pkg;

    typedef enum logic [1:0] {LOAD, START, WAIT} loader_state_t;

    typedef enum logic [2:0] {
        BANK_ALPHA,
        BANK_BETA,
        BANK_A,
        BANK_B,
        BANK_C,
        BANK_NONE
    } bank_t;

    // Frame layout: alpha, beta, A row-major, B row-major, C row-major.
    localparam int OFF_ALPHA = 0;
    localparam int OFF_BETA  = 1;
    localparam int OFF_A     = 2;

    // Offsets of B and C at the default 4x4x4 geometry.
    localparam int DEF_H   = 4;
    localparam int DEF_W   = 4;
    localparam int DEF_ADJ = 4;
    localparam int OFF_B   = OFF_A + DEF_H * DEF_W;
    localparam int OFF_C   = OFF_B + DEF_ADJ * DEF_W;

    function automatic int off_b(input int h, input int w);
        return OFF_A + h * w;
    endfunction

    function automatic int off_c(input int h, input int w, input int adj);
        return off_b(h, w) + adj * w;
    endfunction

    function automatic int frame_len(input int h, input int w, input int adj);
        return off_c(h, w, adj) + h * adj;
    endfunction

endpackage

// File: rtl/gemm_frame_decoder.sv
// Maps a word index within a frame to its target bank, row and column.
module gemm_frame_decoder
    import gemm_pkg::*;
#(
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_ADJUST = 4,
    parameter int IDX_W         = 6
) (
    input  logic [IDX_W-1:0] i_idx,
    output bank_t            o_bank,
    output logic [IDX_W-1:0] o_row,
    output logic [IDX_W-1:0] o_col
);

    localparam int OB = off_b(MATRIX_HEIGHT, MATRIX_WIDTH);
    localparam int OC = off_c(MATRIX_HEIGHT, MATRIX_WIDTH, MATRIX_ADJUST);
    localparam int FL = frame_len(MATRIX_HEIGHT, MATRIX_WIDTH, MATRIX_ADJUST);

    logic [IDX_W-1:0] w_rel;

    // Range-compare the index against the bank offsets; divisors are constants.
    always_comb begin
        o_bank = BANK_NONE;
        o_row  = '0;
        o_col  = '0;
        w_rel  = '0;
        if (i_idx == IDX_W'(OFF_ALPHA)) begin
            o_bank = BANK_ALPHA;
        end else if (i_idx == IDX_W'(OFF_BETA)) begin
            o_bank = BANK_BETA;
        end else if (i_idx < IDX_W'(OB)) begin
            o_bank = BANK_A;
            w_rel  = i_idx - IDX_W'(OFF_A);
            o_row  = w_rel / IDX_W'(MATRIX_WIDTH);
            o_col  = w_rel % IDX_W'(MATRIX_WIDTH);
        end else if (i_idx < IDX_W'(OC)) begin
            o_bank = BANK_B;
            w_rel  = i_idx - IDX_W'(OB);
            o_row  = w_rel / IDX_W'(MATRIX_WIDTH);
            o_col  = w_rel % IDX_W'(MATRIX_WIDTH);
        end else if (i_idx <= IDX_W'(FL - 1)) begin
            o_bank = BANK_C;
            w_rel  = i_idx - IDX_W'(OC);
            o_row  = w_rel / IDX_W'(MATRIX_ADJUST);
            o_col  = w_rel % IDX_W'(MATRIX_ADJUST);
        end
    end

endmodule

// File: rtl/gemm_operand_loader.sv
// Unpacks one length-checked stream frame into GEMM operands, pulses start,
// then freezes the operands until the GEMM stage reports done.
module gemm_operand_loader
    import gemm_pkg::*;
#(
    parameter int DATA_WIDTH    = 64,
    parameter int MATRIX_WIDTH  = 4,
    parameter int MATRIX_HEIGHT = 4,
    parameter int MATRIX_ADJUST = 4
) (
    input  logic                  iclk,
    input  logic                  irst,
    input  logic                  is_valid,
    input  logic [DATA_WIDTH-1:0] is_data,
    input  logic                  is_last,
    output logic                  os_ready,
    output logic [DATA_WIDTH-1:0] oalpha,
    output logic [DATA_WIDTH-1:0] obeta,
    output logic signed [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0]  oa_matrix,
    output logic signed [MATRIX_ADJUST-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0]  ob_matrix,
    output logic signed [MATRIX_HEIGHT-1:0][MATRIX_ADJUST-1:0][DATA_WIDTH-1:0] oc_matrix,
    output logic                  ostart,
    input  logic                  ibusy,
    input  logic                  idone,
    output logic                  oframe_err,
    output logic [15:0]           oframes
);

    localparam int FRAME_LEN = frame_len(MATRIX_HEIGHT, MATRIX_WIDTH, MATRIX_ADJUST);
    localparam int IDX_W     = $clog2(FRAME_LEN);

    loader_state_t    r_state, w_next;
    logic [IDX_W-1:0] r_idx;
    logic             r_ready, r_err, w_start;
    logic [15:0]      r_frames;
    logic             w_xfer, w_at_end, w_good, w_bad;

    bank_t            w_bank;
    logic [IDX_W-1:0] w_row, w_col;

    logic [DATA_WIDTH-1:0] r_alpha, r_beta;
    logic signed [MATRIX_HEIGHT-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0]  r_a;
    logic signed [MATRIX_ADJUST-1:0][MATRIX_WIDTH-1:0][DATA_WIDTH-1:0]  r_b;
    logic signed [MATRIX_HEIGHT-1:0][MATRIX_ADJUST-1:0][DATA_WIDTH-1:0] r_c;

    // Busy is only of interest to external checkers while waiting on GEMM.
    logic w_unused_busy;
    assign w_unused_busy = ibusy;

    // Ready is registered so it stays low throughout reset; it is only ever
    // high in LOAD, so a transfer implies LOAD.
    assign w_xfer   = is_valid && r_ready;
    assign w_at_end = (r_idx == IDX_W'(FRAME_LEN - 1));
    assign w_good   = w_xfer && is_last && w_at_end;
    assign w_bad    = w_xfer && (is_last != w_at_end);

    gemm_frame_decoder #(
        .MATRIX_WIDTH  (MATRIX_WIDTH),
        .MATRIX_HEIGHT (MATRIX_HEIGHT),
        .MATRIX_ADJUST (MATRIX_ADJUST),
        .IDX_W         (IDX_W)
    ) u_dec (
        .i_idx  (r_idx),
        .o_bank (w_bank),
        .o_row  (w_row),
        .o_col  (w_col)
    );

    // Next-state and start pulse.
    always_comb begin
        w_next  = r_state;
        w_start = 1'b0;
        case (r_state)
            LOAD:    if (w_good) w_next = START;
            START: begin
                w_start = 1'b1;
                w_next  = WAIT;
            end
            WAIT:    if (idone) w_next = LOAD;
            default: w_next = LOAD;
        endcase
    end

    // State, ready, word index, error pulse and frame counter.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_state  <= LOAD;
            r_ready  <= 1'b0;
            r_idx    <= '0;
            r_err    <= 1'b0;
            r_frames <= '0;
        end else begin
            r_state <= w_next;
            r_ready <= (w_next == LOAD);
            r_err   <= w_bad;
            if (w_xfer)
                r_idx <= (w_good || w_bad) ? '0 : r_idx + IDX_W'(1);
            if (r_state == START)
                r_frames <= r_frames + 16'd1;
        end
    end

    // Operand write: the accepted word lands in the register its index selects.
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            r_alpha <= '0;
            r_beta  <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_c     <= '0;
        end else if (w_xfer) begin
            case (w_bank)
                BANK_ALPHA: r_alpha <= is_data;
                BANK_BETA:  r_beta  <= is_data;
                BANK_A: begin
                    for (int i = 0; i < MATRIX_HEIGHT; i++)
                        for (int j = 0; j < MATRIX_WIDTH; j++)
                            if (w_row == IDX_W'(i) && w_col == IDX_W'(j))
                                r_a[i][j] <= is_data;
                end
                BANK_B: begin
                    for (int i = 0; i < MATRIX_ADJUST; i++)
                        for (int j = 0; j < MATRIX_WIDTH; j++)
                            if (w_row == IDX_W'(i) && w_col == IDX_W'(j))
                                r_b[i][j] <= is_data;
                end
                BANK_C: begin
                    for (int i = 0; i < MATRIX_HEIGHT; i++)
                        for (int j = 0; j < MATRIX_ADJUST; j++)
                            if (w_row == IDX_W'(i) && w_col == IDX_W'(j))
                                r_c[i][j] <= is_data;
                end
                default: ;
            endcase
        end
    end

    assign os_ready   = r_ready;
    assign ostart     = w_start;
    assign oframe_err = r_err;
    assign oframes    = r_frames;
    assign oalpha     = r_alpha;
    assign obeta      = r_beta;
    assign oa_matrix  = r_a;
    assign ob_matrix  = r_b;
    assign oc_matrix  = r_c;

endmodule

// File: tb/tb_gemm_operand_loader.sv
// Directed + randomized bench for gemm_operand_loader against a frame-image model.
module tb_gemm_operand_loader;

    localparam int DW  = 64;
    localparam int H   = 4;
    localparam int W   = 4;
    localparam int ADJ = 4;
    localparam int FL  = 2 + H * W + ADJ * W + H * ADJ;

    logic          iclk = 1'b0;
    logic          irst = 1'b1;
    logic          is_valid = 1'b0;
    logic [DW-1:0] is_data = '0;
    logic          is_last = 1'b0;
    logic          ibusy = 1'b0;
    logic          idone = 1'b0;
    logic          os_ready, ostart, oframe_err;
    logic [DW-1:0] oalpha, obeta;
    logic signed [H-1:0][W-1:0][DW-1:0]   oa_matrix;
    logic signed [ADJ-1:0][W-1:0][DW-1:0] ob_matrix;
    logic signed [H-1:0][ADJ-1:0][DW-1:0] oc_matrix;
    logic [15:0]   oframes;

    gemm_operand_loader #(
        .DATA_WIDTH(DW), .MATRIX_WIDTH(W), .MATRIX_HEIGHT(H), .MATRIX_ADJUST(ADJ)
    ) dut (
        .iclk(iclk), .irst(irst), .is_valid(is_valid), .is_data(is_data),
        .is_last(is_last), .os_ready(os_ready), .oalpha(oalpha), .obeta(obeta),
        .oa_matrix(oa_matrix), .ob_matrix(ob_matrix), .oc_matrix(oc_matrix),
        .ostart(ostart), .ibusy(ibusy), .idone(idone),
        .oframe_err(oframe_err), .oframes(oframes)
    );

    always #5 iclk = ~iclk;

    // Model: the image of words as they would sit at their frame positions.
    logic [DW-1:0] img [FL];
    logic [DW-1:0] fr  [FL];
    logic [DW-1:0] fr_ref [FL];
    int m_idx, m_frames, m_starts, m_errs, m_evt;
    int n_checks, n_errs;
    int n_start_seen = 0;
    int n_err_seen = 0;

    always @(negedge iclk) begin
        if (ostart === 1'b1)     n_start_seen <= n_start_seen + 1;
        if (oframe_err === 1'b1) n_err_seen   <= n_err_seen + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [1023:0] obs, input logic [1023:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errs++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < FL; k++) img[k] = '0;
        m_idx = 0;
        m_frames = 0;
    endtask

    function automatic logic [1023:0] exp_bank(input int off, input int rows, input int cols);
        logic [1023:0] v;
        v = '0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++)
                v[(r * cols + c) * DW +: DW] = img[off + r * cols + c];
        return v;
    endfunction

    task automatic check_regs(input string tag);
        chk({tag, "_alpha"}, oalpha, img[0]);
        chk({tag, "_beta"},  obeta,  img[1]);
        chk({tag, "_A"}, oa_matrix, exp_bank(2, H, W));
        chk({tag, "_B"}, ob_matrix, exp_bank(2 + H * W, ADJ, W));
        chk({tag, "_C"}, oc_matrix, exp_bank(2 + H * W + ADJ * W, H, ADJ));
    endtask

    // Offer one word (after an optional idle gap) and wait for it to be taken.
    task automatic push(input logic [DW-1:0] d, input logic l, input int gap);
        int n;
        is_valid = 1'b0;
        repeat (gap) begin
            is_data = {$urandom, $urandom};
            is_last = 1'($urandom);
            @(negedge iclk);
        end
        is_valid = 1'b1; is_data = d; is_last = l;
        n = 0;
        while (!os_ready && n < 50) begin
            @(negedge iclk);
            n++;
        end
        m_evt = 0;
        if (!os_ready) begin
            chk("ready_timeout", os_ready, 1);
            is_valid = 1'b0;
            return;
        end
        @(negedge iclk);
        is_valid = 1'b0;
        is_data = {$urandom, $urandom};
        is_last = 1'($urandom);
        img[m_idx] = d;
        if (l && m_idx == FL - 1) begin
            m_evt = 1; m_idx = 0; m_frames++; m_starts++;
        end else if (l || m_idx == FL - 1) begin
            m_evt = 2; m_idx = 0; m_errs++;
        end else begin
            m_idx++;
        end
    endtask

    task automatic send(input int n, input int last_at, input bit gaps);
        for (int k = 0; k < n; k++) begin
            push(fr[k], k == last_at, gaps ? int'($urandom_range(0, 3)) : 0);
            chk("word_start", ostart, m_evt == 1);
            chk("word_err",   oframe_err, m_evt == 2);
            chk("word_ready", os_ready, m_evt != 1);
        end
    endtask

    task automatic post_good(input string tag);
        @(negedge iclk);
        chk({tag, "_start_once"}, ostart, 0);
        chk({tag, "_wait_ready"}, os_ready, 0);
        chk({tag, "_frames"}, oframes, 16'(m_frames));
        check_regs(tag);
    endtask

    task automatic post_err(input string tag);
        @(negedge iclk);
        chk({tag, "_err_once"}, oframe_err, 0);
        chk({tag, "_frames"}, oframes, 16'(m_frames));
        check_regs(tag);
    endtask

    task automatic gemm_done(input string tag);
        idone = 1'b1;
        ibusy = 1'b0;
        @(negedge iclk);
        idone = 1'b0;
        chk({tag, "_done_ready"}, os_ready, 1);
    endtask

    task automatic rand_frame();
        for (int k = 0; k < FL; k++) fr[k] = {$urandom, $urandom};
    endtask

    initial begin
        n_checks = 0; n_errs = 0; m_starts = 0; m_errs = 0; m_evt = 0;
        clear_model();

        // Reset state
        @(negedge iclk);
        chk("rst_ready", os_ready, 0);
        chk("rst_start", ostart, 0);
        chk("rst_err", oframe_err, 0);
        chk("rst_frames", oframes, 0);
        check_regs("rst");
        irst = 1'b0;
        @(negedge iclk);
        chk("rel_ready", os_ready, 1);

        // Good frame with known values
        fr[0] = 64'd2;
        fr[1] = 64'd3;
        for (int i = 0; i < H; i++)
            for (int j = 0; j < W; j++) fr[2 + i * W + j] = 64'(i * 4 + j);
        for (int i = 0; i < ADJ; i++)
            for (int j = 0; j < W; j++) fr[2 + H * W + i * W + j] = (i == j) ? 64'd1 : 64'd0;
        for (int k = 0; k < H * ADJ; k++) fr[2 + H * W + ADJ * W + k] = 64'd1;
        send(FL, FL - 1, 1'b0);
        post_good("good1");
        chk("good1_a23", oa_matrix[2][3], 64'd11);

        // Backpressure: stream keeps offering while GEMM runs
        ibusy = 1'b1;
        for (int c = 0; c < 20; c++) begin
            is_valid = 1'b1;
            is_data = {$urandom, $urandom};
            is_last = 1'($urandom);
            idone = 1'b0;
            @(negedge iclk);
            chk("bp_ready", os_ready, 0);
        end
        is_valid = 1'b0;
        check_regs("bp");
        gemm_done("bp");

        // Short frame: last on word 10
        rand_frame();
        send(11, 10, 1'b0);
        post_err("short");
        rand_frame();
        for (int k = 0; k < FL; k++) fr_ref[k] = fr[k];
        send(FL, FL - 1, 1'b0);
        post_good("good2");
        gemm_done("good2");

        // Missing last
        rand_frame();
        send(FL, -1, 1'b0);
        post_err("nolast");

        // Gapped valid with the same words as good2
        for (int k = 0; k < FL; k++) fr[k] = fr_ref[k];
        send(FL, FL - 1, 1'b1);
        post_good("gapped");
        gemm_done("gapped");

        // Reset mid-frame, asynchronously
        rand_frame();
        send(21, -1, 1'b0);
        #2 irst = 1'b1;
        #1;
        clear_model();
        chk("mrst_ready", os_ready, 0);
        chk("mrst_start", ostart, 0);
        chk("mrst_err", oframe_err, 0);
        chk("mrst_frames", oframes, 0);
        check_regs("mrst");
        @(negedge iclk);
        chk("mrst_hold_ready", os_ready, 0);
        irst = 1'b0;
        @(negedge iclk);
        chk("mrst_rel_ready", os_ready, 1);
        rand_frame();
        send(FL, FL - 1, 1'b0);
        post_good("fresh");
        gemm_done("fresh");

        @(negedge iclk);
        chk("start_pulses", n_start_seen, m_starts);
        chk("err_pulses", n_err_seen, m_errs);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
